// File: rtl/viu_alu_pipe.sv
// Vector integer ALU functional unit: LANES element ops per issue, fixed STAGES-cycle latency.
// Stage 1 captures the issue, the ALU is combinational after it, later stages only delay the result.
module viu_alu_pipe #(
  parameter int XLEN    = 64,
  parameter int LANES   = 2,
  parameter int STAGES  = 2,
  parameter int SZ_VLEN = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    val,
  input  logic                    wen,
  input  logic [5:0]              fn,
  input  logic [SZ_VLEN-1:0]      utidx,
  input  logic [LANES-1:0]        lane_en,
  input  logic [LANES*XLEN-1:0]   in0,
  input  logic [LANES*XLEN-1:0]   in1,
  input  logic                    kill,
  output logic                    out_val,
  output logic [LANES-1:0]        wen_masked,
  output logic [LANES*XLEN-1:0]   out,
  output logic                    busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int RD  = (STAGES == 1) ? 1 : STAGES - 1;

  typedef enum logic [4:0] {
    OP_IDX  = 5'd0,  OP_MOV  = 5'd1,  OP_MOVZ = 5'd2,  OP_MOVN = 5'd3,
    OP_ADD  = 5'd4,  OP_SUB  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,  OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_AND  = 5'd11,
    OP_OR   = 5'd12, OP_XOR  = 5'd13, OP_MIN  = 5'd14, OP_MAX  = 5'd15,
    OP_MINU = 5'd16, OP_MAXU = 5'd17
  } op_e;

  // Replace bits above 31 with bit 31 (fill_sign=1) or with zero (fill_sign=0).
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic fill_sign);
    logic [XLEN-1:0] o;
    o = v;
    for (int k = 32; k < XLEN; k++) o[k] = fill_sign & v[31];
    return o;
  endfunction

  // Returns {mask, result}. DW32 operands are pre-extended so the full-width
  // compare/shift gives the correct low word, which is then sign-extended.
  function automatic logic [XLEN:0] lane_op(input logic [5:0] f, input logic [SZ_VLEN-1:0] idx,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic            dw32;
    logic [XLEN-1:0] a_x, b_x, a_z, r;
    logic [SHW-1:0]  sh;
    logic            m;
    dw32 = (XLEN == 64) && !f[5];
    a_x  = dw32 ? ext32(a, 1'b1) : a;
    b_x  = dw32 ? ext32(b, 1'b1) : b;
    a_z  = dw32 ? ext32(a, 1'b0) : a;
    sh   = b[SHW-1:0] & (dw32 ? SHW'(31) : {SHW{1'b1}});
    m    = 1'b1;
    r    = '0;
    case (f[4:0])
      OP_IDX:  r = XLEN'(idx);
      OP_MOV:  r = b;
      OP_MOVZ: begin r = b; m = ~a[0]; end
      OP_MOVN: begin r = b; m = a[0]; end
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a_z >> sh;
      OP_SRA:  r = XLEN'($signed(a_x) >>> sh);
      OP_SLT:  r = XLEN'($signed(a_x) < $signed(b_x));
      OP_SLTU: r = XLEN'(a_x < b_x);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MIN:  r = ($signed(b_x) < $signed(a_x)) ? b : a;
      OP_MAX:  r = ($signed(b_x) > $signed(a_x)) ? b : a;
      OP_MINU: r = (b_x < a_x) ? b : a;
      OP_MAXU: r = (b_x > a_x) ? b : a;
      default: begin r = '0; m = 1'b0; end
    endcase
    if (dw32) r = ext32(r, 1'b1);
    return {m, r};
  endfunction

  logic                  src_wen;
  logic [5:0]            src_fn;
  logic [SZ_VLEN-1:0]    src_utidx;
  logic [LANES-1:0]      src_lane_en;
  logic [LANES*XLEN-1:0] src_in0, src_in1;

  generate
    if (STAGES == 1) begin : g_comb_in
      assign src_wen     = wen;
      assign src_fn      = fn;
      assign src_utidx   = utidx;
      assign src_lane_en = lane_en;
      assign src_in0     = in0;
      assign src_in1     = in1;
    end else begin : g_in_reg
      logic                  wen_q;
      logic [5:0]            fn_q;
      logic [SZ_VLEN-1:0]    utidx_q;
      logic [LANES-1:0]      lane_en_q;
      logic [LANES*XLEN-1:0] in0_q, in1_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wen_q     <= 1'b0;
          fn_q      <= '0;
          utidx_q   <= '0;
          lane_en_q <= '0;
          in0_q     <= '0;
          in1_q     <= '0;
        end else begin
          wen_q     <= wen;
          fn_q      <= fn;
          utidx_q   <= utidx;
          lane_en_q <= lane_en;
          in0_q     <= in0;
          in1_q     <= in1;
        end
      end
      assign src_wen     = wen_q;
      assign src_fn      = fn_q;
      assign src_utidx   = utidx_q;
      assign src_lane_en = lane_en_q;
      assign src_in0     = in0_q;
      assign src_in1     = in1_q;
    end
  endgenerate

  logic [XLEN:0]         lane_res [LANES];
  logic [LANES*XLEN-1:0] res_c;
  logic [LANES-1:0]      wm_c;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_res[g] = lane_op(src_fn, src_utidx + SZ_VLEN'(g),
                                 src_in0[g*XLEN +: XLEN], src_in1[g*XLEN +: XLEN]);
    assign res_c[g*XLEN +: XLEN] = lane_res[g][XLEN-1:0];
    assign wm_c[g] = src_wen & src_lane_en[g] & lane_res[g][XLEN];
  end

  // Handshake: val is a one-cycle issue strobe with no backpressure; kill drops
  // any same-cycle issue and every in-flight valid bit at the next edge.
  logic [STAGES:1] vld_q, vld_d;

  always_comb begin
    vld_d    = vld_q;
    vld_d[1] = val & ~kill;
    for (int k = 2; k <= STAGES; k++) vld_d[k] = vld_q[k-1] & ~kill;
  end

  logic [LANES*XLEN-1:0] res_q [RD];
  logic [LANES-1:0]      wm_q  [RD];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k < RD; k++) begin
        res_q[k] <= '0;
        wm_q[k]  <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      res_q[0] <= res_c;
      wm_q[0]  <= wm_c;
      for (int k = 1; k < RD; k++) begin
        res_q[k] <= res_q[k-1];
        wm_q[k]  <= wm_q[k-1];
      end
    end
  end

  assign out_val    = vld_q[STAGES];
  assign out        = res_q[RD-1];
  assign wen_masked = wm_q[RD-1] & {LANES{out_val}};

  generate
    if (STAGES == 1) begin : g_no_busy
      assign busy = 1'b0;
    end else begin : g_busy
      assign busy = |vld_q[STAGES-1:1];
    end
  endgenerate

endmodule

// File: tb/tb_viu_alu_pipe.sv
// Self-checking bench for viu_alu_pipe: directed cases, kill/reset scenarios and a
// randomized sweep, with results matched against an expected queue.
module tb_viu_alu_pipe;
  localparam int XLEN    = 64;
  localparam int LANES   = 2;
  localparam int STAGES  = 2;
  localparam int SZ_VLEN = 8;
  localparam int DW      = LANES * XLEN;
  localparam int EW      = DW + LANES;

  logic                 clk, reset_n, val, wen, kill;
  logic [5:0]           fn;
  logic [SZ_VLEN-1:0]   utidx;
  logic [LANES-1:0]     lane_en;
  logic [DW-1:0]        in0, in1;
  logic                 out_val, busy;
  logic [LANES-1:0]     wen_masked;
  logic [DW-1:0]        out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  viu_alu_pipe #(.XLEN(XLEN), .LANES(LANES), .STAGES(STAGES), .SZ_VLEN(SZ_VLEN)) dut (
    .clk(clk), .reset_n(reset_n), .val(val), .wen(wen), .fn(fn), .utidx(utidx),
    .lane_en(lane_en), .in0(in0), .in1(in1), .kill(kill), .out_val(out_val),
    .wen_masked(wen_masked), .out(out), .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [DW-1:0] pk(input logic [63:0] l0, input logic [63:0] l1);
    return {l1, l0};
  endfunction

  // Reference lane model: separate 64-bit and 32-bit datapaths.
  function automatic void ref_lane(input logic [5:0] f, input logic [7:0] idx, input int lane,
                                   input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] r, output logic m);
    logic [31:0] a32, b32, r32;
    logic [4:0]  op;
    op  = f[4:0];
    a32 = a[31:0];
    b32 = b[31:0];
    r   = '0;
    r32 = '0;
    m   = (op == 5'd2) ? ~a[0] : (op == 5'd3) ? a[0] : (op <= 5'd17);
    if (f[5]) begin
      case (op)
        5'd0:  r = {56'b0, idx + 8'(lane)};
        5'd1, 5'd2, 5'd3: r = b;
        5'd4:  r = a + b;
        5'd5:  r = a - b;
        5'd6:  r = a << b[5:0];
        5'd7:  r = a >> b[5:0];
        5'd8:  r = $signed(a) >>> b[5:0];
        5'd9:  r = {63'b0, $signed(a) < $signed(b)};
        5'd10: r = {63'b0, a < b};
        5'd11: r = a & b;
        5'd12: r = a | b;
        5'd13: r = a ^ b;
        5'd14: r = ($signed(b) < $signed(a)) ? b : a;
        5'd15: r = ($signed(b) > $signed(a)) ? b : a;
        5'd16: r = (b < a) ? b : a;
        5'd17: r = (b > a) ? b : a;
        default: r = '0;
      endcase
    end else begin
      case (op)
        5'd0:  r32 = {24'b0, idx + 8'(lane)};
        5'd1, 5'd2, 5'd3: r32 = b32;
        5'd4:  r32 = a32 + b32;
        5'd5:  r32 = a32 - b32;
        5'd6:  r32 = a32 << b32[4:0];
        5'd7:  r32 = a32 >> b32[4:0];
        5'd8:  r32 = $signed(a32) >>> b32[4:0];
        5'd9:  r32 = {31'b0, $signed(a32) < $signed(b32)};
        5'd10: r32 = {31'b0, a32 < b32};
        5'd11: r32 = a32 & b32;
        5'd12: r32 = a32 | b32;
        5'd13: r32 = a32 ^ b32;
        5'd14: r32 = ($signed(b32) < $signed(a32)) ? b32 : a32;
        5'd15: r32 = ($signed(b32) > $signed(a32)) ? b32 : a32;
        5'd16: r32 = (b32 < a32) ? b32 : a32;
        5'd17: r32 = (b32 > a32) ? b32 : a32;
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end
  endfunction

  // driver tasks
  task automatic drive(input logic [5:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [LANES-1:0] le, input logic w, input logic [7:0] ix,
                       input logic k);
    val = 1'b1; fn = f; in0 = a; in1 = b; lane_en = le; wen = w; utidx = ix; kill = k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    val  = 1'b0;
    kill = 1'b0;
  endtask

  task automatic push_exp(input logic [DW-1:0] o, input logic [LANES-1:0] wm);
    exp_q.push_back({wm, o});
    exp_cyc_q.push_back(cyc + STAGES);
  endtask

  task automatic issue_exp(input logic [5:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [LANES-1:0] le, input logic w, input logic [7:0] ix,
                           input logic [DW-1:0] eo, input logic [LANES-1:0] ewm);
    drive(f, a, b, le, w, ix, 1'b0);
    push_exp(eo, ewm);
    tick();
  endtask

  task automatic issue_model(input logic [5:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [LANES-1:0] le, input logic w, input logic [7:0] ix);
    logic [DW-1:0]    eo;
    logic [LANES-1:0] ewm;
    logic [63:0]      r;
    logic             m;
    for (int i = 0; i < LANES; i++) begin
      ref_lane(f, ix, i, a[i*64 +: 64], b[i*64 +: 64], r, m);
      eo[i*64 +: 64] = r;
      ewm[i] = w & le[i] & m;
    end
    issue_exp(f, a, b, le, w, ix, eo, ewm);
  endtask

  // scoreboard: compare every result against the queue head
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    int            ec;
    if (reset_n) begin
      if (out_val) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out_val", DW'(out_val), '0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check_eq("latency", DW'(cyc), DW'(ec));
          check_eq("out", out, e[DW-1:0]);
          check_eq("wen_masked", DW'(wen_masked), DW'(e[EW-1:DW]));
        end
      end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
        check_eq("missing_out_val", DW'(out_val), DW'(1));
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
      end
    end
  end

  localparam logic [5:0] ADD64  = {1'b1, 5'd4};
  localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    reset_n = 1'b0; val = 1'b0; kill = 1'b0; wen = 1'b0; fn = '0;
    utidx = '0; lane_en = '0; in0 = '0; in1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_val", DW'(out_val), '0);
    check_eq("rst_busy", DW'(busy), '0);
    check_eq("rst_out", out, '0);
    check_eq("rst_wen_masked", DW'(wen_masked), '0);
    reset_n = 1'b1;

    issue_exp(ADD64, pk(5, ALL1), pk(3, 1), 2'b11, 1'b1, 8'd0, pk(8, 0), 2'b11);
    issue_exp({1'b0, 5'd8}, pk(64'h8000_0000, 0), pk(4, 0), 2'b11, 1'b1, 8'd0,
              pk(64'hFFFF_FFFF_F800_0000, 0), 2'b11);
    issue_exp({1'b0, 5'd7}, pk(64'h8000_0000, 0), pk(4, 0), 2'b11, 1'b1, 8'd0,
              pk(64'h0800_0000, 0), 2'b11);
    issue_exp({1'b1, 5'd2}, pk(0, 1), pk(64'hAA, 64'hBB), 2'b11, 1'b1, 8'd0,
              pk(64'hAA, 64'hBB), 2'b01);
    issue_exp({1'b1, 5'd2}, pk(0, 1), pk(64'hAA, 64'hBB), 2'b00, 1'b1, 8'd0,
              pk(64'hAA, 64'hBB), 2'b00);
    issue_exp({1'b1, 5'd3}, pk(0, 1), pk(64'hAA, 64'hBB), 2'b11, 1'b1, 8'd0,
              pk(64'hAA, 64'hBB), 2'b10);
    issue_exp({1'b0, 5'd4}, pk(64'h7FFF_FFFF, 0), pk(1, 0), 2'b11, 1'b1, 8'd0,
              pk(64'hFFFF_FFFF_8000_0000, 0), 2'b11);
    tick();

    // back-to-back IDX across the index wrap
    issue_exp({1'b1, 5'd0}, '0, '0, 2'b11, 1'b1, 8'd254, pk(254, 255), 2'b11);
    check_eq("busy_idx_first", DW'(busy), DW'(1));
    issue_exp({1'b1, 5'd0}, '0, '0, 2'b11, 1'b1, 8'd255, pk(255, 0), 2'b11);
    check_eq("busy_idx_second", DW'(busy), DW'(1));
    tick();
    check_eq("busy_idx_after", DW'(busy), '0);

    issue_exp({1'b1, 5'd14}, pk(ALL1, ALL1), pk(1, 1), 2'b11, 1'b1, 8'd0, pk(ALL1, ALL1), 2'b11);
    issue_exp({1'b1, 5'd16}, pk(ALL1, ALL1), pk(1, 1), 2'b11, 1'b1, 8'd0, pk(1, 1), 2'b11);
    issue_exp({1'b1, 5'd9},  pk(ALL1, 1), pk(1, ALL1), 2'b11, 1'b1, 8'd0, pk(1, 0), 2'b11);
    issue_exp({1'b1, 5'd10}, pk(ALL1, 1), pk(1, ALL1), 2'b11, 1'b1, 8'd0, pk(0, 1), 2'b11);
    issue_exp({1'b1, 5'd20}, pk(123, 456), pk(7, 8), 2'b11, 1'b1, 8'd0, '0, 2'b00);
    repeat (3) tick();

    // kill with the third of three consecutive issues
    issue_exp(ADD64, pk(1, 2), pk(10, 20), 2'b11, 1'b1, 8'd0, pk(11, 22), 2'b11);
    drive(ADD64, pk(3, 3), pk(3, 3), 2'b11, 1'b1, 8'd0, 1'b0);
    tick();
    drive(ADD64, pk(4, 4), pk(4, 4), 2'b11, 1'b1, 8'd0, 1'b1);
    tick();
    check_eq("kill_out_val", DW'(out_val), '0);
    check_eq("kill_busy", DW'(busy), '0);
    repeat (3) tick();

    // reset while results are in flight
    drive(ADD64, pk(9, 9), pk(1, 1), 2'b11, 1'b1, 8'd0, 1'b0);
    push_exp(pk(10, 10), 2'b11);
    tick();
    drive(ADD64, pk(8, 8), pk(1, 1), 2'b11, 1'b1, 8'd0, 1'b0);
    push_exp(pk(9, 9), 2'b11);
    tick();
    check_eq("pre_rst_out_val", DW'(out_val), DW'(1));
    check_eq("pre_rst_busy", DW'(busy), DW'(1));
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    check_eq("mid_rst_out_val", DW'(out_val), '0);
    check_eq("mid_rst_busy", DW'(busy), '0);
    check_eq("mid_rst_wen_masked", DW'(wen_masked), '0);
    check_eq("mid_rst_out", out, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      check_eq("post_rst_out_val", DW'(out_val), '0);
      check_eq("post_rst_busy", DW'(busy), '0);
    end

    // randomized sweep, mostly legal ops, occasional equal operands and gaps
    for (int n = 0; n < 60; n++) begin
      logic [DW-1:0] a, b;
      logic [5:0]    f;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = a;
      f = {1'(($urandom_range(0, 1))), 5'($urandom_range(0, 21))};
      issue_model(f, a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    check_eq("drain_empty", DW'(exp_q.size()), '0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
